// File: rtl/game_level_fsm.sv
// Reaction-game sequencer: SETUP -> WAIT (countdown) -> PLAY -> GAME_OVER, with an on-chip
// ms timebase, per-channel mole respawn and score-driven levels. GAME_PAUSE_EN adds the pause port.
module game_level_fsm #(
    parameter int CLKS_PER_MS  = 50000,
    parameter int COUNTDOWN_MS = 3000,
    parameter int MAX_MS       = 30000,
    parameter int NUM_MOLES    = 4,
    parameter int SCORE_W      = 12,
    parameter int WIN_SCORE    = 1000,
    parameter int NUM_LEVELS   = 4,
    parameter int LEVEL_STEP   = 250,
    parameter int BASE_MOLE_MS = 1000,
    parameter int LEVEL_DEC_MS = 200,
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int TL_W  = $clog2(MAX_MS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 play,
    input  logic [NUM_MOLES-1:0] mole_complete,
    input  logic [SCORE_W-1:0]   score,
`ifdef GAME_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 score_clear,
    output logic                 wait_flag,
    output logic                 play_flag,
    output logic                 gameover_flag,
    output logic                 won,
    output logic [NUM_MOLES-1:0] new_mole,
    output logic [LVL_W-1:0]     level,
    output logic [15:0]          mole_ms,
    output logic [TL_W-1:0]      time_left_ms,
    output logic [1:0]           state_dbg
);
    localparam int PS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int CD_W = (COUNTDOWN_MS > 0) ? $clog2(COUNTDOWN_MS + 1) : 1;

    typedef enum logic [1:0] {
        S_SETUP = 2'd0,
        S_WAIT  = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic                 play_q;
    logic [PS_W-1:0]      presc, presc_n;
    logic [CD_W-1:0]      cd, cd_n;
    logic [TL_W-1:0]      tl_n;
    logic [LVL_W-1:0]     level_n;
    logic [15:0]          mole_ms_n;
    logic [NUM_MOLES-1:0] mole_n;
    logic                 won_n, clear_n, play_rise, tick, hold, win;

    // Visible time shrinks per level but never reaches zero.
    function automatic logic [15:0] mole_dur(input logic [LVL_W-1:0] l);
        int d;
        d = BASE_MOLE_MS - int'(l) * LEVEL_DEC_MS;
        if (d < 1) d = 1;
        return 16'(d);
    endfunction

    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        presc_n   = presc;
        cd_n      = cd;
        tl_n      = time_left_ms;
        level_n   = level;
        won_n     = won;
        clear_n   = 1'b0;
        mole_n    = '0;
        play_rise = play & ~play_q;
        tick      = (presc == PS_W'(CLKS_PER_MS - 1));
        win       = (int'(score) >= WIN_SCORE);
`ifdef GAME_PAUSE_EN
        hold      = pause & ((state == S_WAIT) | (state == S_PLAY));
`else
        hold      = 1'b0;
`endif
        case (state)
            S_WAIT: begin
                if (!hold) begin
                    presc_n = tick ? '0 : presc + PS_W'(1);
                    if (tick) begin
                        cd_n = cd - CD_W'(1);
                        if (cd == CD_W'(1)) begin
                            state_n = S_PLAY;
                            tl_n    = TL_W'(MAX_MS);
                            mole_n  = '1;
                        end
                    end
                end
            end
            S_PLAY: begin
                if (!hold) begin
                    presc_n = tick ? '0 : presc + PS_W'(1);
                    if (tick && time_left_ms != '0) tl_n = time_left_ms - TL_W'(1);
                    if (int'(level) < NUM_LEVELS - 1 &&
                        int'(score) >= (int'(level) + 1) * LEVEL_STEP)
                        level_n = level + LVL_W'(1);
                    // Win beats a same-cycle timeout; no spawns on the exit edge.
                    if (win) begin
                        state_n = S_OVER;
                        won_n   = 1'b1;
                    end else if (tick && time_left_ms == TL_W'(1)) begin
                        state_n = S_OVER;
                    end else begin
                        mole_n = mole_complete;
                    end
                end
            end
            default: begin
                if (play_rise) begin
                    state_n = S_WAIT;
                    clear_n = 1'b1;
                    won_n   = 1'b0;
                    level_n = '0;
                    cd_n    = CD_W'(COUNTDOWN_MS);
                end
            end
        endcase
        if (state_n != state) presc_n = '0;
        mole_ms_n = mole_dur(level);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_SETUP;
            play_q        <= 1'b0;
            presc         <= '0;
            cd            <= '0;
            time_left_ms  <= '0;
            level         <= '0;
            won           <= 1'b0;
            score_clear   <= 1'b0;
            new_mole      <= '0;
            mole_ms       <= mole_dur('0);
            wait_flag     <= 1'b0;
            play_flag     <= 1'b0;
            gameover_flag <= 1'b0;
        end else begin
            state         <= state_n;
            play_q        <= play;
            presc         <= presc_n;
            cd            <= cd_n;
            time_left_ms  <= tl_n;
            level         <= level_n;
            won           <= won_n;
            score_clear   <= clear_n;
            new_mole      <= mole_n;
            mole_ms       <= mole_ms_n;
            wait_flag     <= (state_n == S_WAIT);
            play_flag     <= (state_n == S_PLAY);
            gameover_flag <= (state_n == S_OVER);
        end
    end
endmodule

// File: tb/tb_game_level_fsm.sv
// Directed bench for game_level_fsm with a 2-cycle ms tick, 3 ms countdown and 20 ms play limit.
// Pause scenario is compiled in when GAME_PAUSE_EN is defined.
module tb_game_level_fsm;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        play = 1'b0;
    logic [3:0]  mole_complete = '0;
    logic [11:0] score = '0;
`ifdef GAME_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        score_clear, wait_flag, play_flag, gameover_flag, won;
    logic [3:0]  new_mole;
    logic [1:0]  level;
    logic [15:0] mole_ms;
    logic [4:0]  time_left_ms;
    logic [1:0]  state_dbg;

    int tests = 0;
    int failed = 0;

    game_level_fsm #(
        .CLKS_PER_MS(2), .COUNTDOWN_MS(3), .MAX_MS(20), .NUM_MOLES(4),
        .WIN_SCORE(1000), .LEVEL_STEP(250)
    ) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .mole_complete(mole_complete),
        .score(score),
`ifdef GAME_PAUSE_EN
        .pause(pause),
`endif
        .score_clear(score_clear), .wait_flag(wait_flag), .play_flag(play_flag),
        .gameover_flag(gameover_flag), .won(won), .new_mole(new_mole), .level(level),
        .mole_ms(mole_ms), .time_left_ms(time_left_ms), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        play = 0; mole_complete = '0; score = '0;
`ifdef GAME_PAUSE_EN
        pause = 0;
`endif
        reset_n = 1; #1;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    // One-cycle play pulse from SETUP/GAME_OVER; returns just after the PLAY-entry edge.
    task automatic start_game();
        play = 1; step();
        play = 0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        reset_n = 1; #1;
        reset_n = 0; #1;
        tests++;
        if ({score_clear, wait_flag, play_flag, gameover_flag, won} !== 5'b0) begin
            failed++; $display("FAIL reset_flags: got %b want 00000",
                {score_clear, wait_flag, play_flag, gameover_flag, won});
        end
        tests++;
        if (new_mole !== 4'h0 || level !== 2'd0 || time_left_ms !== 5'd0 || state_dbg !== 2'd0) begin
            failed++; $display("FAIL reset_regs: got mole=%h lvl=%0d tl=%0d st=%0d want 0 0 0 0",
                new_mole, level, time_left_ms, state_dbg);
        end
        tests++;
        if (mole_ms !== 16'd1000) begin
            failed++; $display("FAIL reset_mole_ms: got %0d want 1000", mole_ms);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        step();
        tests++;
        if (state_dbg !== 2'd0 || wait_flag !== 1'b0) begin
            failed++; $display("FAIL reset_idle: got st=%0d wait=%b want 0 0", state_dbg, wait_flag);
        end
    endtask

    task automatic test_start();
        int clears;
        do_reset();
        play = 1;
        step();
        clears = int'(score_clear);
        tests++;
        if (score_clear !== 1'b1 || wait_flag !== 1'b1 || state_dbg !== 2'd1) begin
            failed++; $display("FAIL start_enter_wait: got clr=%b wait=%b st=%0d want 1 1 1",
                score_clear, wait_flag, state_dbg);
        end
        mole_complete = 4'hF;
        for (int i = 2; i <= 6; i++) begin
            step();
            clears += int'(score_clear);
            tests++;
            if (wait_flag !== 1'b1 || play_flag !== 1'b0 || new_mole !== 4'h0) begin
                failed++; $display("FAIL start_wait_c%0d: got wait=%b play=%b mole=%h want 1 0 0",
                    i, wait_flag, play_flag, new_mole);
            end
            if (i == 3) play = 0;
            if (i == 5) mole_complete = 4'h0;
        end
        step();
        clears += int'(score_clear);
        tests++;
        if (play_flag !== 1'b1 || wait_flag !== 1'b0 || new_mole !== 4'hF || time_left_ms !== 5'd20) begin
            failed++; $display("FAIL start_play_entry: got play=%b wait=%b mole=%h tl=%0d want 1 0 f 20",
                play_flag, wait_flag, new_mole, time_left_ms);
        end
        tests++;
        if (clears !== 1) begin
            failed++; $display("FAIL start_clear_count: got %0d want 1", clears);
        end
        step();
        tests++;
        if (new_mole !== 4'h0) begin
            failed++; $display("FAIL start_spawn_once: got %h want 0", new_mole);
        end
    endtask

    task automatic test_moles();
        do_reset();
        start_game();
        step();
        mole_complete = 4'b0101;
        step();
        tests++;
        if (new_mole !== 4'b0101) begin
            failed++; $display("FAIL moles_0101: got %b want 0101", new_mole);
        end
        mole_complete = 4'b1111;
        step();
        tests++;
        if (new_mole !== 4'b1111) begin
            failed++; $display("FAIL moles_all: got %b want 1111", new_mole);
        end
        mole_complete = 4'b1000;
        step();
        tests++;
        if (new_mole !== 4'b1000) begin
            failed++; $display("FAIL moles_1000: got %b want 1000", new_mole);
        end
        mole_complete = 4'b0000;
        step();
        tests++;
        if (new_mole !== 4'b0000) begin
            failed++; $display("FAIL moles_idle: got %b want 0000", new_mole);
        end
    endtask

    task automatic test_levels_and_win();
        logic [1:0]  exp_lvl [3] = '{2'd1, 2'd2, 2'd2};
        logic [15:0] exp_ms  [3] = '{16'd1000, 16'd800, 16'd600};
        do_reset();
        start_game();
        score = 12'd600;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (level !== exp_lvl[i] || mole_ms !== exp_ms[i]) begin
                failed++; $display("FAIL level_step%0d: got lvl=%0d ms=%0d want %0d %0d",
                    i, level, mole_ms, exp_lvl[i], exp_ms[i]);
            end
        end
        score = 12'd750;
        step();
        step();
        tests++;
        if (level !== 2'd3 || mole_ms !== 16'd400) begin
            failed++; $display("FAIL level_top: got lvl=%0d ms=%0d want 3 400", level, mole_ms);
        end
        score = 12'd999;
        step();
        tests++;
        if (level !== 2'd3 || play_flag !== 1'b1 || won !== 1'b0) begin
            failed++; $display("FAIL level_sat: got lvl=%0d play=%b won=%b want 3 1 0",
                level, play_flag, won);
        end
        score = 12'd1000;
        mole_complete = 4'hF;
        step();
        tests++;
        if (gameover_flag !== 1'b1 || play_flag !== 1'b0 || won !== 1'b1 || new_mole !== 4'h0) begin
            failed++; $display("FAIL win_exit: got go=%b play=%b won=%b mole=%h want 1 0 1 0",
                gameover_flag, play_flag, won, new_mole);
        end
        tests++;
        if (time_left_ms !== 5'd17) begin
            failed++; $display("FAIL win_time_left: got %0d want 17", time_left_ms);
        end
        step();
        tests++;
        if (gameover_flag !== 1'b1 || won !== 1'b1 || level !== 2'd3 || time_left_ms !== 5'd17 ||
            new_mole !== 4'h0) begin
            failed++; $display("FAIL over_hold: got go=%b won=%b lvl=%0d tl=%0d mole=%h want 1 1 3 17 0",
                gameover_flag, won, level, time_left_ms, new_mole);
        end
        mole_complete = 4'h0;
        play = 1;
        step();
        play = 0;
        tests++;
        if (wait_flag !== 1'b1 || score_clear !== 1'b1 || level !== 2'd0 || won !== 1'b0 ||
            gameover_flag !== 1'b0) begin
            failed++; $display("FAIL win_restart: got wait=%b clr=%b lvl=%0d won=%b go=%b want 1 1 0 0 0",
                wait_flag, score_clear, level, won, gameover_flag);
        end
        score = 12'd0;
    endtask

    task automatic test_timeout();
        do_reset();
        start_game();
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 11) begin
                tests++;
                if (play_flag !== 1'b1 || wait_flag !== 1'b0 || score_clear !== 1'b0) begin
                    failed++; $display("FAIL play_rise_in_play: got play=%b wait=%b clr=%b want 1 0 0",
                        play_flag, wait_flag, score_clear);
                end
                play = 0;
            end
            if (i == 10) play = 1;
            if (i == 20) begin
                tests++;
                if (time_left_ms !== 5'd10) begin
                    failed++; $display("FAIL timeout_mid: got %0d want 10", time_left_ms);
                end
            end
            if (i == 39) begin
                tests++;
                if (time_left_ms !== 5'd1 || play_flag !== 1'b1) begin
                    failed++; $display("FAIL timeout_last: got tl=%0d play=%b want 1 1",
                        time_left_ms, play_flag);
                end
                mole_complete = 4'hF;
            end
        end
        tests++;
        if (time_left_ms !== 5'd0 || gameover_flag !== 1'b1 || won !== 1'b0 || play_flag !== 1'b0 ||
            new_mole !== 4'h0) begin
            failed++; $display("FAIL timeout_exit: got tl=%0d go=%b won=%b play=%b mole=%h want 0 1 0 0 0",
                time_left_ms, gameover_flag, won, play_flag, new_mole);
        end
        mole_complete = 4'h0;
        play = 1;
        step();
        play = 0;
        tests++;
        if (wait_flag !== 1'b1 || score_clear !== 1'b1 || level !== 2'd0 || gameover_flag !== 1'b0) begin
            failed++; $display("FAIL timeout_restart: got wait=%b clr=%b lvl=%0d go=%b want 1 1 0 0",
                wait_flag, score_clear, level, gameover_flag);
        end
    endtask

    task automatic test_win_on_final_tick();
        do_reset();
        start_game();
        repeat (39) step();
        score = 12'd1000;
        step();
        tests++;
        if (won !== 1'b1 || gameover_flag !== 1'b1 || time_left_ms !== 5'd0) begin
            failed++; $display("FAIL win_final_tick: got won=%b go=%b tl=%0d want 1 1 0",
                won, gameover_flag, time_left_ms);
        end
        score = 12'd0;
    endtask

    task automatic test_async_reset();
        do_reset();
        start_game();
        score = 12'd600;
        repeat (3) step();
        tests++;
        if (level !== 2'd2 || play_flag !== 1'b1) begin
            failed++; $display("FAIL areset_pre: got lvl=%0d play=%b want 2 1", level, play_flag);
        end
        #2 reset_n = 0;
        #1;
        tests++;
        if (play_flag !== 1'b0 || level !== 2'd0 || time_left_ms !== 5'd0 || mole_ms !== 16'd1000 ||
            state_dbg !== 2'd0 || new_mole !== 4'h0 || won !== 1'b0) begin
            failed++; $display("FAIL areset_now: got play=%b lvl=%0d tl=%0d ms=%0d st=%0d want 0 0 0 1000 0",
                play_flag, level, time_left_ms, mole_ms, state_dbg);
        end
        score = 12'd0;
        @(posedge clk);
        #1 reset_n = 1;
        step();
        tests++;
        if (score_clear !== 1'b0 || state_dbg !== 2'd0) begin
            failed++; $display("FAIL areset_after: got clr=%b st=%0d want 0 0", score_clear, state_dbg);
        end
    endtask

`ifdef GAME_PAUSE_EN
    task automatic test_pause();
        int bad;
        do_reset();
        start_game();
        repeat (3) step();
        tests++;
        if (time_left_ms !== 5'd19) begin
            failed++; $display("FAIL pause_pre: got %0d want 19", time_left_ms);
        end
        pause = 1;
        mole_complete = 4'hF;
        bad = 0;
        repeat (10) begin
            step();
            if (time_left_ms !== 5'd19 || new_mole !== 4'h0 || play_flag !== 1'b1) bad++;
        end
        tests++;
        if (bad !== 0) begin
            failed++; $display("FAIL pause_hold: got %0d bad cycles want 0 (tl=%0d mole=%h)",
                bad, time_left_ms, new_mole);
        end
        pause = 0;
        mole_complete = 4'h0;
        step();
        tests++;
        if (time_left_ms !== 5'd18) begin
            failed++; $display("FAIL pause_resume: got %0d want 18", time_left_ms);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_moles();
        test_levels_and_win();
        test_timeout();
        test_win_on_final_tick();
        test_async_reset();
`ifdef GAME_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
